dffr_shreg: RTL and testbench

//   Parametrised multi-stage register chain for the mcu9t3v3 cell set: WIDTH-bit

---
 rtl/dffr_shreg.sv | 106 ++++++++++
 tb/tb_dffr_shreg.sv | 126 ++++++++++++
 2 files changed

// File: rtl/dffr_shreg.sv
// Multi-stage WIDTH-bit register chain with hold, shift, rotate and clear modes.
// A fill counter and full flag record how many stages hold shifted-in data.
module dffr_shreg #(
    parameter int                 WIDTH   = 8,
    parameter int                 DEPTH   = 4,
    parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}}
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic [1:0]                   mode,
    input  logic [WIDTH-1:0]             i,
    output logic [WIDTH-1:0]             q,
    output logic [WIDTH*DEPTH-1:0]       pq,
    output logic [$clog2(DEPTH+1)-1:0]   cnt,
    output logic                         full
);

    localparam int            CW      = $clog2(DEPTH+1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_SHIFT  = 2'b01;
    localparam logic [1:0] MODE_ROTATE = 2'b10;
    localparam logic [1:0] MODE_CLEAR  = 2'b11;

    logic [WIDTH-1:0] stage_r [DEPTH];
    logic [WIDTH-1:0] stage_s [DEPTH];
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_s;
    logic             full_r;
    logic             full_s;

    // Next-state selection; an unknown mode poisons all state so it is visible in simulation.
    always_comb begin
        stage_s = stage_r;
        cnt_s   = cnt_r;
        full_s  = full_r;
        case (mode)
            MODE_HOLD: begin
                stage_s = stage_r;
            end
            MODE_SHIFT: begin
                stage_s[0] = i;
                for (int k = 1; k < DEPTH; k++) begin
                    stage_s[k] = stage_r[k-1];
                end
                if (cnt_r == CNT_MAX) begin
                    cnt_s = CNT_MAX;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
                full_s = (cnt_s == CNT_MAX);
            end
            MODE_ROTATE: begin
                stage_s[0] = stage_r[DEPTH-1];
                for (int k = 1; k < DEPTH; k++) begin
                    stage_s[k] = stage_r[k-1];
                end
            end
            MODE_CLEAR: begin
                for (int k = 0; k < DEPTH; k++) begin
                    stage_s[k] = RST_VAL;
                end
                cnt_s  = {CW{1'b0}};
                full_s = 1'b0;
            end
            default: begin
                for (int k = 0; k < DEPTH; k++) begin
                    stage_s[k] = {WIDTH{1'bx}};
                end
                cnt_s  = {CW{1'bx}};
                full_s = 1'bx;
            end
        endcase
    end

    // State registers with synchronous active-low reset; unknown reset poisons state.
    always_ff @(posedge clk) begin
        if (nrst == 1'b0) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_r[k] <= RST_VAL;
            end
            cnt_r  <= {CW{1'b0}};
            full_r <= 1'b0;
        end else if (nrst == 1'b1) begin
            stage_r <= stage_s;
            cnt_r   <= cnt_s;
            full_r  <= full_s;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_r[k] <= {WIDTH{1'bx}};
            end
            cnt_r  <= {CW{1'bx}};
            full_r <= 1'bx;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_pq
        assign pq[g*WIDTH +: WIDTH] = stage_r[g];
    end

    assign q    = stage_r[DEPTH-1];
    assign cnt  = cnt_r;
    assign full = full_r;

endmodule

// File: tb/tb_dffr_shreg.sv
// Directed-vector bench for dffr_shreg (WIDTH=8, DEPTH=4, RST_VAL=0).
// Expected values are hand-computed; pq is {stage3, stage2, stage1, stage0}.
module tb_dffr_shreg;

    logic        clk;
    logic        nrst;
    logic [1:0]  mode;
    logic [7:0]  i;
    logic [7:0]  q;
    logic [31:0] pq;
    logic [2:0]  cnt;
    logic        full;

    int n_tests;
    int n_fail;

    dffr_shreg #(
        .WIDTH   (8),
        .DEPTH   (4),
        .RST_VAL (8'h00)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .mode (mode),
        .i    (i),
        .q    (q),
        .pq   (pq),
        .cnt  (cnt),
        .full (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one edge with the given controls, then sample 1ns after the edge.
    task automatic step(input logic r, input logic [1:0] m, input logic [7:0] d);
        nrst = r;
        mode = m;
        i    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [31:0] e_pq,
                               input logic [2:0] e_cnt, input logic e_full);
        check_eq({tag, "_pq"},   64'(pq),   64'(e_pq));
        check_eq({tag, "_q"},    64'(q),    64'(e_pq[31:24]));
        check_eq({tag, "_cnt"},  64'(cnt),  64'(e_cnt));
        check_eq({tag, "_full"}, 64'(full), 64'(e_full));
    endtask

    logic [7:0] fill_v [4];
    logic [7:0] rot_q  [4];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        nrst    = 1'b0;
        mode    = 2'b01;
        i       = 8'hFF;

        // 1: reset dominates shift
        step(1'b0, 2'b01, 8'hFF);
        step(1'b0, 2'b01, 8'hFF);
        check_state("reset", 32'h0000_0000, 3'd0, 1'b0);

        // 2: fill and latency
        fill_v = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        for (int n = 0; n < 4; n++) begin
            step(1'b1, 2'b01, fill_v[n]);
            check_eq("fill_cnt",  64'(cnt),     64'(n + 1));
            check_eq("fill_s0",   64'(pq[7:0]), 64'(fill_v[n]));
            check_eq("fill_full", 64'(full),    64'(n == 3));
        end
        check_state("fill", 32'hA1A2_A3A4, 3'd4, 1'b1);

        // 3: saturation drops the oldest word
        step(1'b1, 2'b01, 8'hA5);
        check_state("sat", 32'hA2A3_A4A5, 3'd4, 1'b1);

        // 4: rotate ignores i, cnt unchanged
        rot_q = '{8'hA3, 8'hA4, 8'hA5, 8'hA2};
        for (int n = 0; n < 4; n++) begin
            step(1'b1, 2'b10, (n < 2) ? 8'h00 : 8'hFF);
            check_eq("rot_q",   64'(q),   64'(rot_q[n]));
            check_eq("rot_cnt", 64'(cnt), 64'd4);
        end
        check_state("rot", 32'hA2A3_A4A5, 3'd4, 1'b1);

        // 5: clear, two shifts, hold, clear
        step(1'b1, 2'b11, 8'h77);
        check_state("clr0", 32'h0000_0000, 3'd0, 1'b0);
        step(1'b1, 2'b01, 8'hB1);
        step(1'b1, 2'b01, 8'hB2);
        check_eq("hold_cnt0", 64'(cnt), 64'd2);
        for (int n = 0; n < 3; n++) begin
            step(1'b1, 2'b00, 8'h99);
            check_eq("hold_cnt", 64'(cnt), 64'd2);
        end
        check_state("hold", 32'h0000_B1B2, 3'd2, 1'b0);
        step(1'b1, 2'b11, 8'h55);
        check_state("clr1", 32'h0000_0000, 3'd0, 1'b0);

        // 6: reset mid-operation, then first shift lands in stage0
        step(1'b1, 2'b01, 8'hC1);
        step(1'b1, 2'b01, 8'hC2);
        step(1'b1, 2'b01, 8'hC3);
        check_state("mid3", 32'h00C1_C2C3, 3'd3, 1'b0);
        step(1'b0, 2'b01, 8'hEE);
        check_state("midrst", 32'h0000_0000, 3'd0, 1'b0);
        step(1'b1, 2'b01, 8'h5C);
        check_state("post", 32'h0000_005C, 3'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
